ps2_key_tracker: RTL and testbench
==================================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named CLOCK_50 and reset.
REQ-002 The block SHALL have parameter NUM_KEYS, default 4: number of tracked keys (1..32).
REQ-003 The block SHALL have parameter KEY_MAP, default {9'h075,9'h072,9'h06B,9'h074}: 9 bits per key, packed {ext, code}; key i is at [9i+8:9i]; the default is keypad 8/2/4/6.
REQ-004 The block SHALL have parameter HIST_DEPTH, default 4: event FIFO depth, a power of 2 in the range 2..16.
REQ-005 The block SHALL have port CLOCK_50 as input, width 1: system clock.
REQ-006 The block SHALL have port reset as input, width 1: synchronous, active-high reset.
REQ-007 The block SHALL have port received_data as input, width 8: PS/2 byte from the controller.
REQ-008 The block SHALL have port received_data_en as input, width 1: one-cycle strobe qualifying received_data.
REQ-009 The block SHALL have port key_down as output, width NUM_KEYS: level output, 1 while key i is held.
REQ-010 The block SHALL have port key_press as output, width NUM_KEYS: one-cycle pulse on a key's up-to-down transition only.
REQ-011 The block SHALL have port last_code as output, width 9: {ext, code} of the most recent make event.
REQ-012 The block SHALL have port evt_data as output, width 10: FIFO head, packed {brk, ext, code}.
REQ-013 The block SHALL have port evt_valid as output, width 1: FIFO non-empty.
REQ-014 The block SHALL have port evt_ready as input, width 1: consumer pop; a pop occurs when evt_valid and evt_ready are both high.
REQ-015 The block SHALL have port overflow as output, width 1: sticky flag, set when an event is dropped.

Function
REQ-016 The parser FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 then F0 seen), and SHALL advance only on cycles with received_data_en high.
REQ-017 On E0 the FSM SHALL go IDLE->EXT; on F0 it SHALL go IDLE->BRK and EXT->EXT_BRK; on any other byte it SHALL complete an event and return to IDLE.
REQ-018 The completed event SHALL carry ext=1 for the EXT and EXT_BRK states, and brk=1 for the BRK and EXT_BRK states.
REQ-019 Bytes E1, AA, FA, FE, EE, 00 and FF SHALL return the FSM to IDLE and SHALL produce no event.
REQ-020 A redundant prefix (F0 in BRK or EXT_BRK, E0 in any non-IDLE state) SHALL leave the state unchanged.
REQ-021 Latency: for a final byte strobed at cycle N, key_down, key_press, last_code and the FIFO push SHALL all take effect at edge N+1.
REQ-022 On a make event matching KEY_MAP[i], key_down[i] SHALL be set; key_press[i] SHALL pulse only if key_down[i] was 0, so typematic repeats produce no pulse.
REQ-023 On a break event matching KEY_MAP[i], key_down[i] SHALL be cleared and no pulse SHALL be produced.
REQ-024 Matching SHALL compare all 9 bits, so 75 and E0 75 are distinct keys.
REQ-025 If KEY_MAP contains duplicate entries, all matching indices SHALL update.
REQ-026 last_code SHALL update on every make event, including unmapped keys.
REQ-027 Every completed event, mapped or not, SHALL be pushed to the FIFO.
REQ-028 evt_data SHALL be the oldest entry, and SHALL be valid whenever evt_valid is high.
REQ-029 If the FIFO is full and no pop occurs in that cycle, a push SHALL drop the new event, keep the FIFO contents, and set overflow.
REQ-030 A push and a pop in the same cycle SHALL both be honoured, including when the FIFO is full; the count stays unchanged and nothing is dropped.
REQ-031 A pop while empty SHALL be ignored.
REQ-032 The FIFO pointers SHALL wrap modulo HIST_DEPTH, and the count SHALL be clog2(HIST_DEPTH)+1 bits wide.

Reset
REQ-033 While reset is high, the FSM SHALL go to IDLE, and key_down, key_press, last_code, the FIFO pointers, the count and overflow SHALL all be 0; evt_valid SHALL therefore be 0.
REQ-034 A reset arriving mid-sequence (for example after E0 F0) SHALL discard the partial sequence, so that a following byte is parsed from IDLE.
REQ-035 When reset and received_data_en are both high, reset SHALL win.

Structure
REQ-036 A shared package SHALL hold the prefix constants (E0, F0), the ignored-byte list, the 9-bit key-code type, the 10-bit event type and the FSM state encoding.
REQ-037 The FIFO SHALL be a single sub-module, ps2_event_fifo, parametrised by width and depth; the parser and key table SHALL stay in the top-level module.

Verification
REQ-038 Bench test 1: send 75 -> at N+1 key_down=0001, key_press=0001 for one cycle, last_code=075, evt_data=0_0_75.
REQ-039 Bench test 2: send 75 75 75, then F0 75 -> exactly one key_press[0] pulse, key_down[0] falls after the 75 that follows F0, and 4 events are queued with the last being 1_0_75.
REQ-040 Bench test 3: send E0 75 and E0 F0 75 -> key_down[0] never sets, last_code=175, and the events are 0_1_75 and 1_1_75.
REQ-041 Bench test 4: with evt_ready=0, send 5 makes at HIST_DEPTH=4 -> 4 entries held, overflow=1, and the fifth event is lost; then hold evt_ready=1 and send a byte in the same cycle as a pop while full -> no drop.
REQ-042 Bench test 5: send E0 F0, pulse reset, then send 75 -> after reset every output is 0, and 75 is then reported as a plain make (key_down[0]=1).
REQ-043 Bench test 6: send FA, AA and E1 -> no event, FSM in IDLE, evt_valid=0.

Source files
------------

// File: rtl/ps2_key_tracker_pkg.sv
// Shared types and constants for the PS/2 key tracker: prefixes, ignored bytes,
// key-code and event payloads, parser state encoding.
package ps2_key_tracker_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam int unsigned KEY_CODE_W = 9;
  localparam int unsigned EVT_W      = 10;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_code_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } evt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_t;

  // Controller/status bytes that abort a sequence and never form an event
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

endpackage

// File: rtl/ps2_key_tracker_event.sv
// Event FIFO: power-of-2 depth, combinational head, simultaneous push/pop when full,
// sticky overflow on a dropped push.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic             overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic do_pop_c;
  logic do_push_c;

  // A pop frees the slot the same cycle, so a full FIFO still accepts push+pop
  assign do_pop_c  = pop && (count != '0);
  assign do_push_c = push && ((count != CW'(DEPTH)) || do_pop_c);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push_c && !do_pop_c)      count <= count + CW'(1);
      else if (do_pop_c && !do_push_c) count <= count - CW'(1);
      if (push && !do_push_c) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_push_c && !reset) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign not_empty = (count != '0);

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code parser with per-key held/press tracking, last make code and an event FIFO.
module ps2_key_tracker
  import ps2_key_tracker_pkg::*;
#(
  parameter int unsigned          NUM_KEYS   = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_MAP   = {9'h075, 9'h072, 9'h06B, 9'h074},
  parameter int unsigned          HIST_DEPTH = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [8:0]          last_code,
  output logic [9:0]          evt_data,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic                overflow
);

  parse_state_t state;
  parse_state_t state_next;
  logic         evt_fire_c;
  evt_t         evt_c;
  key_code_t    evt_key_c;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Prefixes accumulate; redundant prefixes hold; anything else ends the sequence
  always_comb begin
    state_next = state;
    if (received_data_en) begin
      if (received_data == PREFIX_EXT) begin
        if (state == ST_IDLE) state_next = ST_EXT;
      end else if (received_data == PREFIX_BRK) begin
        case (state)
          ST_IDLE: state_next = ST_BRK;
          ST_EXT:  state_next = ST_EXT_BRK;
          default: state_next = state;
        endcase
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  always_comb begin
    evt_fire_c = 1'b0;
    evt_c      = '0;
    evt_c.brk  = (state == ST_BRK) || (state == ST_EXT_BRK);
    evt_c.ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
    evt_c.code = received_data;
    if (received_data_en && !reset &&
        received_data != PREFIX_EXT && received_data != PREFIX_BRK &&
        !is_ignored(received_data))
      evt_fire_c = 1'b1;
  end

  assign evt_key_c = '{ext: evt_c.ext, code: evt_c.code};

  // Key table: duplicate map entries all update from the same event
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_down  <= '0;
      key_press <= '0;
      last_code <= '0;
    end else begin
      key_press <= '0;
      if (evt_fire_c) begin
        if (!evt_c.brk) last_code <= evt_key_c;
        for (int i = 0; i < NUM_KEYS; i++) begin
          if (KEY_MAP[9*i +: 9] == evt_key_c) begin
            if (evt_c.brk) begin
              key_down[i] <= 1'b0;
            end else begin
              key_down[i]  <= 1'b1;
              key_press[i] <= ~key_down[i];
            end
          end
        end
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (HIST_DEPTH)
  ) u_fifo (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .push      (evt_fire_c),
    .push_data (evt_c),
    .pop       (evt_ready),
    .head_data (evt_data),
    .not_empty (evt_valid),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker; key 0 is mapped to keypad 8 (75) so the vectors read naturally.
module tb_ps2_key_tracker;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic [3:0] key_down;
  logic [3:0] key_press;
  logic [8:0] last_code;
  logic [9:0] evt_data;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_key_tracker #(
    .NUM_KEYS   (4),
    .KEY_MAP    ({9'h074, 9'h06B, 9'h072, 9'h075}),
    .HIST_DEPTH (4)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .key_down         (key_down),
    .key_press        (key_press),
    .last_code        (last_code),
    .evt_data         (evt_data),
    .evt_valid        (evt_valid),
    .evt_ready        (evt_ready),
    .overflow         (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Strobe one byte; on return the N+1 edge has passed
  task automatic send(input logic [7:0] b);
    tick();
    received_data    = b;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [9:0] exp);
    check(tag, 32'(evt_valid), 32'h1);
    check(tag, 32'(evt_data), 32'(exp));
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_down"},  32'(key_down),  32'h0);
    check({tag, "_press"}, 32'(key_press), 32'h0);
    check({tag, "_last"},  32'(last_code), 32'h0);
    check({tag, "_valid"}, 32'(evt_valid), 32'h0);
    check({tag, "_ovf"},   32'(overflow),  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check_idle_outputs("rst");

    // Test 1: plain make of a mapped key
    send(8'h75);
    check("t1_down",  32'(key_down),  32'h1);
    check("t1_press", 32'(key_press), 32'h1);
    check("t1_last",  32'(last_code), 32'h075);
    check("t1_evt",   32'(evt_data),  32'h075);
    check("t1_valid", 32'(evt_valid), 32'h1);
    tick();
    check("t1_press_gone", 32'(key_press), 32'h0);

    // Test 2: typematic repeats then release
    do_reset();
    send(8'h75);
    check("t2_press1", 32'(key_press), 32'h1);
    send(8'h75);
    check("t2_press2", 32'(key_press), 32'h0);
    send(8'h75);
    check("t2_press3", 32'(key_press), 32'h0);
    check("t2_down_held", 32'(key_down), 32'h1);
    send(8'hF0);
    check("t2_down_f0", 32'(key_down), 32'h1);
    send(8'h75);
    check("t2_down_rel",  32'(key_down),  32'h0);
    check("t2_press_rel", 32'(key_press), 32'h0);
    check("t2_last_rel",  32'(last_code), 32'h075);
    check("t2_ovf",       32'(overflow),  32'h0);
    pop_check("t2_e0", 10'h075);
    pop_check("t2_e1", 10'h075);
    pop_check("t2_e2", 10'h075);
    pop_check("t2_e3", 10'h275);
    check("t2_empty", 32'(evt_valid), 32'h0);

    // Test 3: extended key is distinct from the plain one
    do_reset();
    send(8'hE0);
    send(8'h75);
    check("t3_down_mk", 32'(key_down),  32'h0);
    check("t3_last_mk", 32'(last_code), 32'h175);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("t3_down_br", 32'(key_down),  32'h0);
    check("t3_last_br", 32'(last_code), 32'h175);
    pop_check("t3_e0", 10'h175);
    pop_check("t3_e1", 10'h375);

    // Test 4: overflow, then push+pop while full
    do_reset();
    send(8'h11);
    send(8'h12);
    send(8'h13);
    send(8'h14);
    check("t4_ovf_full", 32'(overflow), 32'h0);
    send(8'h15);
    check("t4_ovf_drop", 32'(overflow), 32'h1);
    check("t4_head",     32'(evt_data), 32'h011);
    check("t4_last",     32'(last_code), 32'h015);
    tick();
    received_data    = 8'h16;
    received_data_en = 1'b1;
    evt_ready        = 1'b1;
    tick();
    received_data_en = 1'b0;
    evt_ready        = 1'b0;
    pop_check("t4_e0", 10'h012);
    pop_check("t4_e1", 10'h013);
    pop_check("t4_e2", 10'h014);
    pop_check("t4_e3", 10'h016);
    check("t4_empty", 32'(evt_valid), 32'h0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("t4_pop_empty", 32'(evt_valid), 32'h0);
    send(8'h20);
    pop_check("t4_after_empty_pop", 10'h020);
    check("t4_ovf_sticky", 32'(overflow), 32'h1);

    // Test 5: reset mid-sequence, with a strobe colliding with reset
    do_reset();
    send(8'hE0);
    send(8'hF0);
    tick();
    reset            = 1'b1;
    received_data    = 8'h75;
    received_data_en = 1'b1;
    tick();
    reset            = 1'b0;
    received_data_en = 1'b0;
    check_idle_outputs("t5_rst");
    send(8'h75);
    check("t5_down", 32'(key_down),  32'h1);
    check("t5_last", 32'(last_code), 32'h075);
    pop_check("t5_evt", 10'h075);

    // Test 6: status bytes abort and produce nothing
    do_reset();
    send(8'hFA);
    send(8'hAA);
    send(8'hE1);
    check("t6_valid", 32'(evt_valid), 32'h0);
    send(8'hE0);
    send(8'hAA);
    send(8'h6B);
    check("t6_down", 32'(key_down), 32'h4);
    check("t6_press", 32'(key_press), 32'h4);
    pop_check("t6_evt", 10'h06B);
    check("t6_empty", 32'(evt_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
